// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches words from instruction memory ahead of
// the IF stage and queues {IR, NPC} pairs. A taken-branch redirect flushes the
// queue and restarts fetch; halt stops new requests from being issued.
module instr_prefetch_buffer #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 10,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  input  logic          halt,
  output logic          if_valid,
  output logic [31:0]   if_ir,
  output logic [AW-1:0] if_npc,
  input  logic          if_ready,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  // RUN: free to issue; WAIT: response pending; DROP: pending response is stale
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] pc;

  logic [31:0]   ir_mem  [DEPTH];
  logic [AW-1:0] npc_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   hold_ir;
  logic [AW-1:0] hold_npc;

  logic pop;
  logic push;
  logic issue;

  // A redirect wins over everything: it blocks issue and suppresses push/pop.
  assign if_valid = (count != '0);
  assign pop      = if_valid & if_ready;
  assign push     = (state == ST_WAIT) & imem_rvalid & ~redir_valid;
  assign issue    = (state == ST_RUN) & ~halt & ~redir_valid & (count != CNT_FULL);

  // Head read; when empty the last head value seen is presented instead.
  assign if_ir  = if_valid ? ir_mem[rd_ptr]  : hold_ir;
  assign if_npc = if_valid ? npc_mem[rd_ptr] : hold_npc;

  // Next-state decode of the single-outstanding-request fetch controller
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (issue) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid)      state_nxt = ST_RUN;
        else if (redir_valid) state_nxt = ST_DROP;
      end
      ST_DROP: if (imem_rvalid) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Fetch control: state, pc, request strobe/address and busy flag
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= ST_RUN;
      busy      <= 1'b0;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != ST_RUN);
      imem_req <= issue;
      if (redir_valid) begin
        pc <= redir_pc;
      end else if (issue) begin
        imem_addr <= pc;
        pc        <= pc + 1'b1;
      end
    end
  end

  // Queue bookkeeping: pointers, occupancy and the held head for the empty case
  always_ff @(posedge clk1) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      hold_ir  <= '0;
      hold_npc <= '0;
    end else begin
      if (if_valid) begin
        hold_ir  <= ir_mem[rd_ptr];
        hold_npc <= npc_mem[rd_ptr];
      end
      if (redir_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Queue storage; the address of the outstanding request is still on imem_addr
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= imem_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: a directed vector table, a set
// of hand-written corner sequences, and a randomized run against a queue-based
// reference model.
module tb_instr_prefetch_buffer;

  localparam int            DEPTH    = 4;
  localparam int            AW       = 10;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam int            MASK     = (1 << AW) - 1;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic          halt = 1'b0;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [AW-1:0] if_npc;
  logic          if_ready = 1'b0;
  logic          busy;

  always #5 clk1 = ~clk1;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk1(clk1), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt),
    .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc), .if_ready(if_ready),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] ir; logic [AW-1:0] npc; } pair_t;
  pair_t       m_q[$];
  int          m_pc = 0;
  int          m_addr = 0;
  bit          m_req = 0;
  bit          m_out = 0;
  bit          m_drop = 0;
  logic [31:0] m_last_ir = '0;
  int          m_last_npc = 0;

  // ---------------- memory responder ----------------
  bit auto_mem = 0;
  int mem_lat = 0;
  int slow_addr = -1;
  bit pend = 0;
  int plat = 0;
  int paddr = 0;

  function automatic logic [31:0] mem_f(input int a);
    return 32'(a + 100);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One clock cycle: memory answers, model advances, edge, then compare.
  task automatic tick();
    pair_t p;
    bit    issue_n;
    bit    got;
    if (auto_mem) begin
      if (imem_req === 1'b1) begin
        pend  = 1;
        paddr = int'(imem_addr);
        plat  = (paddr == slow_addr) ? 3 : ((mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat);
      end
      imem_rvalid = 1'b0;
      if (pend) begin
        if (plat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_f(paddr);
          pend        = 0;
        end else begin
          plat--;
        end
      end
    end
    if (rst) begin
      m_q.delete();
      m_pc = int'(RESET_PC); m_addr = 0; m_req = 0; m_out = 0; m_drop = 0;
      m_last_ir = '0; m_last_npc = 0;
    end else begin
      issue_n = !m_out && !halt && !redir_valid && (m_q.size() < DEPTH);
      got     = m_out && imem_rvalid;
      if (redir_valid) m_q.delete();
      else begin
        if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
        if (got && !m_drop) begin
          p.ir  = imem_rdata;
          p.npc = AW'((m_addr + 1) & MASK);
          m_q.push_back(p);
        end
      end
      if (got) begin m_out = 0; m_drop = 0; end
      else if (m_out && redir_valid) m_drop = 1;
      m_req = issue_n;
      if (issue_n) begin
        m_addr = m_pc;
        m_pc   = (m_pc + 1) & MASK;
        m_out  = 1;
      end
      if (redir_valid) m_pc = int'(redir_pc);
    end
    @(posedge clk1);
    #1;
    redir_valid = 1'b0;
    chk("mdl.req",   32'(imem_req),  32'(m_req));
    chk("mdl.addr",  32'(imem_addr), 32'(m_addr));
    chk("mdl.valid", 32'(if_valid),  32'(m_q.size() > 0));
    chk("mdl.busy",  32'(busy),      32'(m_out));
    if (m_q.size() > 0) begin
      chk("mdl.ir",  if_ir,       m_q[0].ir);
      chk("mdl.npc", 32'(if_npc), 32'(m_q[0].npc));
      m_last_ir  = m_q[0].ir;
      m_last_npc = int'(m_q[0].npc);
    end else begin
      chk("mdl.ir_hold",  if_ir,       m_last_ir);
      chk("mdl.npc_hold", 32'(if_npc), 32'(m_last_npc));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redir_valid = 1'b0; pend = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (imem_req !== 1'b1 && k < 40) begin tick(); k++; end
    n_chk++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: timeout, imem_req got 0 required 1", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (if_valid !== 1'b1 && k < 40) begin tick(); k++; end
    n_chk++;
    if (if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: timeout, if_valid got 0 required 1", name);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst, rvalid; logic [31:0] rdata; logic ready;
    logic          req; logic [AW-1:0] addr; logic valid; logic [31:0] ir;
    logic [AW-1:0] npc; logic busy;
  } vec_t;
  vec_t tbl [13];

  function automatic vec_t mk(input int r, input int rv, input int rd, input int rdy,
                              input int rq, input int ad, input int v, input int ir,
                              input int np, input int b);
    vec_t m;
    m.rst = r[0]; m.rvalid = rv[0]; m.rdata = rd; m.ready = rdy[0];
    m.req = rq[0]; m.addr = ad[AW-1:0]; m.valid = v[0]; m.ir = ir;
    m.npc = np[AW-1:0]; m.busy = b[0];
    return m;
  endfunction

  initial begin
    int          vcyc [$];
    pair_t       seen [$];
    int          cyc;
    int          k;

    // Fill with if_ready=0 using a same-cycle memory, then one pop.
    tbl[0]  = mk(1, 0,   0, 0,  0, 0, 0,   0, 0, 0);
    tbl[1]  = mk(0, 0,   0, 0,  1, 0, 0,   0, 0, 1);
    tbl[2]  = mk(0, 1, 100, 0,  0, 0, 1, 100, 1, 0);
    tbl[3]  = mk(0, 0,   0, 0,  1, 1, 1, 100, 1, 1);
    tbl[4]  = mk(0, 1, 101, 0,  0, 1, 1, 100, 1, 0);
    tbl[5]  = mk(0, 0,   0, 0,  1, 2, 1, 100, 1, 1);
    tbl[6]  = mk(0, 1, 102, 0,  0, 2, 1, 100, 1, 0);
    tbl[7]  = mk(0, 0,   0, 0,  1, 3, 1, 100, 1, 1);
    tbl[8]  = mk(0, 1, 103, 0,  0, 3, 1, 100, 1, 0);
    tbl[9]  = mk(0, 0,   0, 0,  0, 3, 1, 100, 1, 0);
    tbl[10] = mk(0, 0,   0, 0,  0, 3, 1, 100, 1, 0);
    tbl[11] = mk(0, 0,   0, 1,  0, 3, 1, 101, 2, 0);
    tbl[12] = mk(0, 0,   0, 0,  1, 4, 1, 101, 2, 1);

    auto_mem = 0;
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
      if_ready = tbl[i].ready; halt = 1'b0; redir_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d.req", i),   32'(imem_req),  32'(tbl[i].req));
      chk($sformatf("tbl%0d.addr", i),  32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d.valid", i), 32'(if_valid),  32'(tbl[i].valid));
      chk($sformatf("tbl%0d.ir", i),    if_ir,          tbl[i].ir);
      chk($sformatf("tbl%0d.npc", i),   32'(if_npc),    32'(tbl[i].npc));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),      32'(tbl[i].busy));
    end
    imem_rvalid = 1'b0;
    auto_mem = 1;

    // Throughput: same-cycle memory, always ready -> one pair every 2 cycles.
    mem_lat = 0; if_ready = 1'b1;
    do_reset();
    for (cyc = 0; cyc < 16; cyc++) begin
      tick();
      if (if_valid === 1'b1) begin
        pair_t p;
        p.ir = if_ir; p.npc = if_npc;
        seen.push_back(p);
        vcyc.push_back(cyc);
      end
    end
    chk("thru.count_ge3", 32'(seen.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      chk($sformatf("thru.ir%0d", i),  seen[i].ir,        32'(100 + i));
      chk($sformatf("thru.npc%0d", i), 32'(seen[i].npc),  32'(i + 1));
      if (i > 0) chk($sformatf("thru.gap%0d", i), 32'(vcyc[i] - vcyc[i-1]), 32'd2);
    end

    // Redirect to 20 while the request for 5 is outstanding (slow response).
    slow_addr = 5; mem_lat = 0; if_ready = 1'b1;
    do_reset();
    k = 0;
    while (!(imem_req === 1'b1 && imem_addr === 10'd5) && k < 60) begin tick(); k++; end
    chk("redir.req5_seen", 32'(imem_req === 1'b1 && imem_addr === 10'd5), 32'd1);
    redir_valid = 1'b1; redir_pc = 10'd20;
    tick();
    chk("redir.drop_busy",  32'(busy),     32'd1);
    chk("redir.drop_empty", 32'(if_valid), 32'd0);
    wait_req("redir.wait_req");
    chk("redir.addr20", 32'(imem_addr), 32'd20);
    wait_valid("redir.wait_valid");
    chk("redir.npc21", 32'(if_npc), 32'd21);
    chk("redir.ir120", if_ir,       32'd120);
    slow_addr = -1;

    // Redirect together with a response and a pop: no DROP, restart at target.
    mem_lat = 0; if_ready = 1'b0;
    do_reset();
    k = 0;
    while (!(m_q.size() >= 2 && imem_req === 1'b1) && k < 40) begin tick(); k++; end
    chk("same.setup_valid", 32'(if_valid), 32'd1);
    if_ready = 1'b1; redir_valid = 1'b1; redir_pc = 10'd40;
    tick();
    chk("same.empty",   32'(if_valid), 32'd0);
    chk("same.no_drop", 32'(busy),     32'd0);
    tick();
    chk("same.req",    32'(imem_req),  32'd1);
    chk("same.addr40", 32'(imem_addr), 32'd40);

    // PC wrap at 2^AW-1.
    mem_lat = 0; if_ready = 1'b1;
    do_reset();
    redir_valid = 1'b1; redir_pc = 10'd1023;
    tick();
    wait_req("wrap.wait_req1");
    chk("wrap.addr1023", 32'(imem_addr), 32'd1023);
    wait_valid("wrap.wait_valid");
    chk("wrap.npc0",  32'(if_npc), 32'd0);
    chk("wrap.ir",    if_ir,       32'd1123);
    wait_req("wrap.wait_req2");
    chk("wrap.addr0", 32'(imem_addr), 32'd0);

    // Halt while a request is outstanding: it completes, nothing new issues.
    mem_lat = 2; if_ready = 1'b0;
    do_reset();
    wait_req("halt.wait_req");
    halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("halt.noreq%0d", i), 32'(imem_req), 32'd0);
    end
    chk("halt.pushed", 32'(if_valid), 32'd1);
    chk("halt.ir",     if_ir,         32'd100);
    chk("halt.idle",   32'(busy),     32'd0);
    halt = 1'b0;
    tick();
    chk("halt.resume_req",  32'(imem_req),  32'd1);
    chk("halt.resume_addr", 32'(imem_addr), 32'd1);

    // Reset during WAIT; the late response arrives in RUN and is ignored.
    mem_lat = 0; if_ready = 1'b0;
    do_reset();
    wait_valid("rstw.wait_valid");
    mem_lat = 3;
    wait_req("rstw.wait_req");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; halt = 1'b1;
    chk("rstw.req",   32'(imem_req),  32'd0);
    chk("rstw.addr",  32'(imem_addr), 32'd0);
    chk("rstw.valid", 32'(if_valid),  32'd0);
    chk("rstw.ir",    if_ir,          32'd0);
    chk("rstw.npc",   32'(if_npc),    32'd0);
    chk("rstw.busy",  32'(busy),      32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("rstw.late_ignored", 32'(if_valid), 32'd0);
    halt = 1'b0;
    tick();
    chk("rstw.req_after",  32'(imem_req),  32'd1);
    chk("rstw.addr_after", 32'(imem_addr), 32'(RESET_PC));

    // Randomized traffic against the reference model.
    mem_lat = -1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      if_ready = ($urandom_range(0, 3) != 0);
      halt     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        redir_valid = 1'b1;
        redir_pc = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, MASK))
                                               : AW'(1020 + $urandom_range(0, 3));
      end
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
